// File: rtl/wddl_inv_stage.sv
// Purpose : WDDL dual-rail invert/buffer stage with PRE/EVAL sequencing and rail-violation monitor.
// Latency : a word captured in EVAL cycle t is presented in cycle t+STAGES; err_flag follows the violating cycle by 1.
// Backpressure: none; one word per two cycles, upstream aligns to phase.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   in_t/in_f, in_valid   dual-rail input word, qualified in EVAL only
//   inv_mask              per-bit rail swap (1 = NOT, 0 = buffer), sampled with the word
//   err_clr               clears the violation counter
//   phase                 1 = EVAL cycle, 0 = PRE cycle
//   out_t/out_f/out_valid dual-rail output word, 00 on every bit when not valid
//   err_flag, err_cnt     one-cycle violation pulse, saturating violation-cycle count
module wddl_inv_stage #(
    parameter int WIDTH     = 8,
    parameter int STAGES    = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_t,
    input  logic [WIDTH-1:0]     in_f,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     inv_mask,
    input  logic                 err_clr,
    output logic                 phase,
    output logic [WIDTH-1:0]     out_t,
    output logic [WIDTH-1:0]     out_f,
    output logic                 out_valid,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [0:0] ST_PRE  = 1'b0;
    localparam logic [0:0] ST_EVAL = 1'b1;

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       state;
    logic [WIDTH-1:0] pipe_t [STAGES];
    logic [WIDTH-1:0] pipe_f [STAGES];
    logic [STAGES-1:0] pipe_v;

    logic             capture;
    logic [WIDTH-1:0] same_rail;
    logic             eval_viol;
    logic             pre_viol;
    logic             viol;
    logic             word_ok;
    logic [WIDTH-1:0] xf_t;
    logic [WIDTH-1:0] xf_f;
    logic [WIDTH-1:0] st0_t;
    logic [WIDTH-1:0] st0_f;

    // PRE/EVAL toggles every cycle; reset parks it in PRE so the first
    // released cycle is a precharge cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_PRE;
        end else begin
            state <= (state == ST_PRE) ? ST_EVAL : ST_PRE;
        end
    end

    assign phase   = (state == ST_EVAL);
    assign capture = phase & in_valid;

    // A bit with equal rails (00 or 11) is not a legal evaluated value.
    assign same_rail = ~(in_t ^ in_f);
    assign eval_viol = capture & (|same_rail);
    // Any raised rail during precharge breaks the WDDL return-to-zero rule.
    assign pre_viol  = ~phase & (|(in_t | in_f));
    assign viol      = eval_viol | pre_viol;
    assign word_ok   = capture & ~(|same_rail);

    // Inversion in dual-rail is a rail swap, so no logic gate touches the data.
    assign xf_t = (in_t & ~inv_mask) | (in_f & inv_mask);
    assign xf_f = (in_f & ~inv_mask) | (in_t & inv_mask);

    // Non-captured and illegal words become a precharge bubble, so 11
    // can never enter the pipeline.
    assign st0_t = word_ok ? xf_t : '0;
    assign st0_f = word_ok ? xf_f : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe_t[i] <= '0;
                pipe_f[i] <= '0;
                pipe_v[i] <= 1'b0;
            end
        end else begin
            pipe_t[0] <= st0_t;
            pipe_f[0] <= st0_f;
            pipe_v[0] <= word_ok;
            for (int i = 1; i < STAGES; i++) begin
                pipe_t[i] <= pipe_t[i-1];
                pipe_f[i] <= pipe_f[i-1];
                pipe_v[i] <= pipe_v[i-1];
            end
        end
    end

    assign out_t     = pipe_t[STAGES-1];
    assign out_f     = pipe_f[STAGES-1];
    assign out_valid = pipe_v[STAGES-1];

    // Counter counts violating cycles, not violating bits. A clear in the
    // same cycle as a violation keeps that violation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else begin
            err_flag <= viol;
            if (err_clr) begin
                err_cnt <= viol ? CNT_ONE : '0;
            end else if (viol && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_wddl_inv_stage.sv
module tb_wddl_inv_stage;

    localparam int W    = 8;
    localparam int S    = 2;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  in_t;
    logic [W-1:0]  in_f;
    logic          in_valid;
    logic [W-1:0]  inv_mask;
    logic          err_clr;
    logic          phase;
    logic [W-1:0]  out_t;
    logic [W-1:0]  out_f;
    logic          out_valid;
    logic          err_flag;
    logic [CW-1:0] err_cnt;

    always #5 clk = ~clk;

    wddl_inv_stage #(.WIDTH(W), .STAGES(S), .ERR_CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_t     (in_t),
        .in_f     (in_f),
        .in_valid (in_valid),
        .inv_mask (inv_mask),
        .err_clr  (err_clr),
        .phase    (phase),
        .out_t    (out_t),
        .out_f    (out_f),
        .out_valid(out_valid),
        .err_flag (err_flag),
        .err_cnt  (err_cnt)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Behavioural model: absolute cycle number, current phase, and a table
    // of output words keyed by the cycle they must appear in.
    int             g      = 0;
    bit             ph_m   = 1'b0;
    logic [2*W-1:0] sched [int];
    bit             flag_m = 1'b0;
    int             cnt_m  = 0;
    bit             chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, g);
    endtask

    task automatic model_step();
        bit viol;
        bit bad;
        viol = 1'b0;
        if (!rst_n) begin
            ph_m   = 1'b0;
            sched.delete();
            flag_m = 1'b0;
            cnt_m  = 0;
        end else begin
            if (ph_m && in_valid) begin
                bad = 1'b0;
                for (int i = 0; i < W; i++) if (in_t[i] == in_f[i]) bad = 1'b1;
                if (bad) viol = 1'b1;
                else sched[g + S] = {(in_t & ~inv_mask) | (in_f & inv_mask),
                                     (in_f & ~inv_mask) | (in_t & inv_mask)};
            end
            if (!ph_m && ((in_t | in_f) != '0)) viol = 1'b1;
            flag_m = viol;
            if (err_clr) cnt_m = viol ? 1 : 0;
            else if (viol) cnt_m = (cnt_m + 1 > CMAX) ? CMAX : cnt_m + 1;
            ph_m = !ph_m;
        end
        g++;
    endtask

    // Single compare process: every cycle, mid-cycle, against the model.
    always @(negedge clk) begin : cmp
        logic [2*W-1:0] w;
        bit             v;
        bit             code_ok;
        if (chk_en) begin
            v = sched.exists(g);
            w = v ? sched[g] : '0;
            chk("phase",     32'(phase),     32'(ph_m));
            chk("out_t",     32'(out_t),     32'(w[2*W-1:W]));
            chk("out_f",     32'(out_f),     32'(w[W-1:0]));
            chk("out_valid", 32'(out_valid), 32'(v));
            chk("err_flag",  32'(err_flag),  32'(flag_m));
            chk("err_cnt",   32'(err_cnt),   32'(cnt_m));
            code_ok = out_valid ? ((out_t ^ out_f) == '1) : ((out_t | out_f) == '0);
            chk("rail_code", 32'(code_ok), 32'd1);
        end
    end

    task automatic idle();
        in_t = '0; in_f = '0; in_valid = 1'b0; inv_mask = '0; err_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic to_phase(input bit p);
        while (ph_m != p) begin idle(); tick(); end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; idle(); tick(); rst_n = 1'b1;
    endtask

    // Drive a violation appropriate to the current phase.
    task automatic drive_viol();
        if (ph_m) begin in_t = '0; in_f = '0; in_valid = 1'b1; end
        else begin in_t = 8'h10; in_f = '0; in_valid = 1'b0; end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;

        // Single word with partial inversion
        to_phase(1'b1);
        in_t = 8'hA5; in_f = 8'h5A; inv_mask = 8'h0F; in_valid = 1'b1;
        tick(); idle(); tick();
        @(negedge clk);
        chk("lit_inv_t", 32'(out_t), 32'hAA);
        chk("lit_inv_f", 32'(out_f), 32'h55);
        chk("lit_inv_v", 32'(out_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("lit_bubble_rails", 32'({out_t, out_f}), 32'h0);
        chk("lit_bubble_v", 32'(out_valid), 32'd0);

        // Back-to-back words on consecutive EVAL cycles
        to_phase(1'b1);
        in_t = 8'h01; in_f = 8'hFE; in_valid = 1'b1;
        tick(); idle(); tick();
        in_t = 8'h80; in_f = 8'h7F; in_valid = 1'b1;
        @(negedge clk);
        chk("lit_b2b_w1", 32'({out_valid, out_t, out_f}), 32'h101FE);
        tick(); idle();
        @(negedge clk);
        chk("lit_b2b_gap", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("lit_b2b_w2", 32'({out_valid, out_t, out_f}), 32'h1807F);

        // Illegal EVAL word
        do_reset();
        to_phase(1'b1);
        in_t = 8'h03; in_f = 8'h01; in_valid = 1'b1;
        tick(); idle();
        @(negedge clk);
        chk("lit_eval_flag", 32'(err_flag), 32'd1);
        chk("lit_eval_cnt", 32'(err_cnt), 32'd1);
        tick();
        @(negedge clk);
        chk("lit_eval_drop", 32'({out_valid, out_t, out_f}), 32'h0);

        // PRE violation, saturation, clear-with-violation, clear
        to_phase(1'b0);
        in_t = 8'h10;
        tick(); idle();
        @(negedge clk);
        chk("lit_pre_flag", 32'(err_flag), 32'd1);
        chk("lit_pre_cnt", 32'(err_cnt), 32'd2);
        for (int k = 0; k < 4; k++) begin
            idle(); drive_viol(); tick();
            @(negedge clk);
            chk("lit_b2b_flag", 32'(err_flag), 32'd1);
        end
        chk("lit_sat_cnt", 32'(err_cnt), 32'd3);
        idle(); drive_viol(); err_clr = 1'b1;
        tick(); idle();
        @(negedge clk);
        chk("lit_clr_viol", 32'(err_cnt), 32'd1);
        err_clr = 1'b1;
        tick(); idle();
        @(negedge clk);
        chk("lit_clr", 32'(err_cnt), 32'd0);

        // Reset one cycle after a capture discards the word
        to_phase(1'b0);
        in_t = 8'h10;
        tick();
        to_phase(1'b1);
        in_t = 8'h3C; in_f = 8'hC3; in_valid = 1'b1;
        tick();
        rst_n = 1'b0; idle();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("lit_rst_phase", 32'(phase), 32'd0);
        chk("lit_rst_cnt", 32'(err_cnt), 32'd0);
        chk("lit_rst_v", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            chk("lit_rst_novalid", 32'(out_valid), 32'd0);
        end

        // Randomized traffic with occasional resets, clears and corruption
        for (int c = 0; c < 2000; c++) begin
            int idx;
            rst_n    = ($urandom_range(99) != 0);
            err_clr  = ($urandom_range(19) == 0);
            inv_mask = W'($urandom);
            if (ph_m) begin
                in_valid = ($urandom_range(3) != 0);
                in_t = W'($urandom);
                in_f = ~in_t;
                if ($urandom_range(7) == 0) begin
                    idx = $urandom_range(W - 1);
                    in_f[idx] = ~in_f[idx];
                end
            end else begin
                in_valid = $urandom_range(1) != 0;
                if ($urandom_range(5) == 0) begin
                    in_t = W'($urandom); in_f = W'($urandom);
                end else begin
                    in_t = '0; in_f = '0;
                end
            end
            tick();
        end
        rst_n = 1'b1;
        idle();
        for (int k = 0; k < S + 2; k++) tick();
        @(negedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/wddl_inv_stage.md
WDDL_INV_STAGE -- requirements
Module: wddl_inv_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of dual-rail bits per word (>=1).
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth in clock cycles (>=1).
REQ-003 SHALL have parameter ERR_CNT_W, default 8, width of the violation counter (>=2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_t  input  WIDTH  true rail of input word.
REQ-007 SHALL have port in_f  input  WIDTH  false rail of input word.
REQ-008 SHALL have port in_valid  input  1  upstream presents an evaluated word this cycle.
REQ-009 SHALL have port inv_mask  input  WIDTH  per-bit invert enable; 1 = swap rails (logical NOT), 0 = pass (buffer).
REQ-010 SHALL have port err_clr  input  1  clears violation counter.
REQ-011 SHALL have port phase  output  1  1 = evaluate cycle, 0 = precharge cycle.
REQ-012 SHALL have port out_t  output  WIDTH  true rail of output word.
REQ-013 SHALL have port out_f  output  WIDTH  false rail of output word.
REQ-014 SHALL have port out_valid  output  1  out_t/out_f carry an evaluated word.
REQ-015 SHALL have port err_flag  output  1  one-cycle pulse, violation detected previous cycle.
REQ-016 SHALL have port err_cnt  output  ERR_CNT_W  saturating count of violation cycles.

Function
REQ-017 SHALL run a two-state FSM PRE/EVAL, alternating every cycle after reset; first cycle after reset release is PRE; phase = 1 exactly in EVAL.
REQ-018 SHALL capture a word only in a cycle with phase=1 and in_valid=1; in_valid in PRE is ignored (no capture, no error).
REQ-019 SHALL transform captured bit i as out_t[i]=inv_mask[i]?in_f[i]:in_t[i], out_f[i]=inv_mask[i]?in_t[i]:in_f[i]; inv_mask sampled in the capture cycle.
REQ-020 SHALL insert a precharge bubble (all rails 0, valid 0) into stage 0 on every non-capture cycle.
REQ-021 SHALL shift the word and valid through STAGES registers; a word captured in cycle t appears on outputs with out_valid=1 in cycle t+STAGES.
REQ-022 SHALL guarantee every output bit is 00 whenever out_valid=0 and 01/10 whenever out_valid=1; 11 never leaves the block.
REQ-023 SHALL flag an EVAL violation when a captured word has any bit with in_t==in_f (00 or 11); such word is replaced by a bubble (00, valid 0).
REQ-024 SHALL flag a PRE violation when any bit of in_t|in_f is 1 during a PRE cycle.
REQ-025 SHALL NOT flag EVAL cycles with in_valid=0, regardless of rail values.
REQ-026 SHALL pulse err_flag for one cycle in cycle t+1 for each violating cycle t; back-to-back violations give err_flag high continuously.
REQ-027 SHALL increment err_cnt by 1 per violating cycle (not per bit), saturating at 2^ERR_CNT_W-1.
REQ-028 SHALL set err_cnt to 0 on err_clr without violation, to 1 on err_clr with simultaneous violation.
REQ-029 SHALL sustain throughput of one word per two cycles with no backpressure; upstream aligns to phase.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, set FSM to PRE (phase=0 next cycle), all pipeline stages to 00/valid 0, out_t=out_f=0, out_valid=0, err_flag=0, err_cnt=0.
REQ-031 SHALL discard in-flight words on reset mid-operation; no out_valid pulse from pre-reset captures after release.
REQ-032 SHALL perform no capture or violation check in a cycle where rst_n=0.

Verification
REQ-033 SHALL test WIDTH=8, STAGES=2: EVAL capture in_t=0xA5, in_f=0x5A, inv_mask=0x0F -> two cycles later out_t=0xAA, out_f=0x55, out_valid=1; following cycle out_t=out_f=0, out_valid=0.
REQ-034 SHALL test back-to-back words every EVAL (0x01/0xFE, 0x80/0x7F, mask 0x00) -> out_valid alternates 1,0,1 with words in order.
REQ-035 SHALL test EVAL capture in_t=0x03, in_f=0x01 -> err_flag pulse next cycle, err_cnt=1, output stays 00 with out_valid=0 at t+2.
REQ-036 SHALL test PRE cycle with in_t=0x10 -> err_flag pulse, err_cnt increments; with ERR_CNT_W=2, four further violations -> err_cnt holds 3; err_clr with violation -> err_cnt=1.
REQ-037 SHALL test rst_n=0 for one cycle one cycle after a valid capture -> no out_valid pulse afterwards, err_cnt=0, phase=0 in first post-reset cycle.
